// File: rtl/pseq_pkg.sv
// pseq_pkg: op encodings and fault codes shared by program_sequencer and its bench.
package pseq_pkg;

  typedef enum logic [2:0] {
    PSEQ_NOP  = 3'd0,
    PSEQ_INC  = 3'd1,
    PSEQ_JMP  = 3'd2,
    PSEQ_JREL = 3'd3,
    PSEQ_CALL = 3'd4,
    PSEQ_RET  = 3'd5
  } pseq_op_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_OVF  = 2'd1,
    FLT_UNF  = 2'd2,
    FLT_ILL  = 2'd3
  } fault_code_e;

endpackage

// File: rtl/pseq_ras.sv
// pseq_ras: DEPTH x WIDTH return-address LIFO. The top entry is read
// combinationally so a RET completes in the same cycle it is sampled.
// The storage array is not reset; only the occupancy counter is.
module pseq_ras #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         mclk,
  input  logic                         mrst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Write slot is the first free entry; the top is the entry just below it.
  assign wr_idx  = AW'(depth_q);
  assign rd_idx  = AW'(depth_q - DW'(1));
  assign top     = mem[rd_idx];
  assign depth   = depth_q;

  // Occupancy: at most one of push/pop is requested per cycle.
  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
  end

  // Occupancy register, cleared by reset.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) depth_q <= '0;
    else         depth_q <= depth_d;
  end

  // Storage write; contents survive reset and are don't-care above depth.
  always_ff @(posedge mclk) begin
    if (do_push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: instruction address generator with INC / JMP / CALL / RET
// and a return-address stack. Freezes with a sticky fault code on stack
// overflow, underflow or illegal op; only mrst_n clears it.
// Optional macro PSEQ_RELATIVE_EN enables op 3 (JREL, pc += signed offset);
// without it op 3 is illegal and no offset adder exists.
module program_sequencer
  import pseq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       mclk,
  input  logic                       mrst_n,
  input  logic                       mclk_en,
  input  logic                       i_halt,
  input  logic [2:0]                 i_op,
  input  logic [WIDTH-1:0]           i_target,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_fault,
  output logic [1:0]                 o_fault_code
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fault_q, fault_d;
  fault_code_e      code_q, code_d;
  logic             step;
  logic             push, pop;
  logic [WIDTH-1:0] ret_addr, ras_top;
  logic             ras_full, ras_empty;

  assign step     = mclk_en & ~i_halt & ~fault_q;
  assign ret_addr = pc_q + WIDTH'(1);

  pseq_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
    .mclk   (mclk),
    .mrst_n (mrst_n),
    .push   (push),
    .pop    (pop),
    .din    (ret_addr),
    .top    (ras_top),
    .depth  (o_depth),
    .full   (ras_full),
    .empty  (ras_empty)
  );

  // Op decode: next pc, stack request and fault capture for this step.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    code_d  = code_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (step) begin
      case (pseq_op_e'(i_op))
        PSEQ_NOP: ;
        PSEQ_INC: pc_d = ret_addr;
        PSEQ_JMP: pc_d = i_target;
`ifdef PSEQ_RELATIVE_EN
        // Unsigned add of the two's-complement offset wraps correctly.
        PSEQ_JREL: pc_d = pc_q + i_target;
`endif
        PSEQ_CALL: begin
          if (ras_full) begin
            fault_d = 1'b1;
            code_d  = FLT_OVF;
          end else begin
            push = 1'b1;
            pc_d = i_target;
          end
        end
        PSEQ_RET: begin
          if (ras_empty) begin
            fault_d = 1'b1;
            code_d  = FLT_UNF;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: begin
          fault_d = 1'b1;
          code_d  = FLT_ILL;
        end
      endcase
    end
  end

  // pc and sticky fault registers.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      pc_q    <= '0;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign o_data       = pc_q;
  assign o_full       = ras_full;
  assign o_empty      = ras_empty;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer (WIDTH=8, DEPTH=4): directed scenarios plus
// randomized ops checked against a queue-based reference model.
module tb_program_sequencer;

  localparam int W = 8;
  localparam int D = 4;

  logic         mclk = 1'b0;
  logic         mrst_n = 1'b0;
  logic         mclk_en = 1'b0;
  logic         i_halt = 1'b0;
  logic [2:0]   i_op = 3'd0;
  logic [W-1:0] i_target = '0;
  logic [W-1:0] o_data;
  logic [2:0]   o_depth;
  logic         o_full, o_empty, o_fault;
  logic [1:0]   o_fault_code;

  int checks = 0;
  int errs   = 0;

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  bit           m_flt;
  logic [1:0]   m_code;

  program_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .mclk(mclk), .mrst_n(mrst_n), .mclk_en(mclk_en), .i_halt(i_halt),
    .i_op(i_op), .i_target(i_target), .o_data(o_data), .o_depth(o_depth),
    .o_full(o_full), .o_empty(o_empty), .o_fault(o_fault),
    .o_fault_code(o_fault_code)
  );

  always #5 mclk = ~mclk;

  task automatic mdl_reset();
    m_pc = '0; m_stk.delete(); m_flt = 0; m_code = 2'd0;
  endtask

  task automatic mdl_fault(input logic [1:0] c);
    m_flt = 1; m_code = c;
  endtask

  task automatic mdl_step(input logic [2:0] op, input logic [W-1:0] t, input bit en, input bit hlt);
    if (!en || hlt || m_flt) return;
    case (op)
      3'd0: ;
      3'd1: m_pc = m_pc + 8'd1;
      3'd2: m_pc = t;
`ifdef PSEQ_RELATIVE_EN
      3'd3: m_pc = W'(int'(m_pc) + int'($signed(t)));
`endif
      3'd4: if (m_stk.size() == D) mdl_fault(2'd1);
            else begin m_stk.push_back(m_pc + 8'd1); m_pc = t; end
      3'd5: if (m_stk.size() == 0) mdl_fault(2'd2);
            else m_pc = m_stk.pop_back();
      default: mdl_fault(2'd3);
    endcase
  endtask

  // Drive one op on the negedge, let the posedge take it, sample 1 ns later.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] t, input bit en = 1, input bit hlt = 0);
    @(negedge mclk);
    i_op = op; i_target = t; mclk_en = en; i_halt = hlt;
    @(posedge mclk);
    #1;
    mdl_step(op, t, en, hlt);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    mrst_n = 0; mclk_en = 0; i_op = 3'd0;
    #1;
    mdl_reset();
    @(negedge mclk);
    mrst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_data !== 8'h00 || o_depth !== 3'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
        o_fault !== 1'b0 || o_fault_code !== 2'd0) begin
      errs++;
      $display("FAIL reset: data=%h depth=%0d empty=%b full=%b fault=%b code=%0d want 00/0/1/0/0/0",
               o_data, o_depth, o_empty, o_full, o_fault, o_fault_code);
    end
  endtask

  task automatic test_inc();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      do_op(3'd1, 8'h00);
      checks++;
      if (o_data !== W'(i)) begin
        errs++; $display("FAIL inc_%0d: pc=%h want %h", i, o_data, W'(i));
      end
    end
    do_op(3'd2, 8'hFF);
    do_op(3'd1, 8'h00);
    checks++;
    if (o_data !== 8'h00) begin errs++; $display("FAIL inc_wrap: pc=%h want 00", o_data); end
  endtask

  task automatic test_call_ret();
    logic [W-1:0] exp_pc[4] = '{8'h40, 8'h80, 8'h41, 8'h11};
    logic [2:0]   exp_dp[4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    logic [2:0]   ops[4]    = '{3'd4, 3'd4, 3'd5, 3'd5};
    logic [W-1:0] tg[4]     = '{8'h40, 8'h80, 8'h00, 8'h00};
    do_reset();
    do_op(3'd2, 8'h10);
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], tg[i]);
      checks++;
      if (o_data !== exp_pc[i] || o_depth !== exp_dp[i]) begin
        errs++; $display("FAIL call_ret_%0d: pc=%h depth=%0d want %h/%0d", i, o_data, o_depth, exp_pc[i], exp_dp[i]);
      end
    end
    checks++;
    if (o_empty !== 1'b1 || o_fault !== 1'b0) begin
      errs++; $display("FAIL call_ret_empty: empty=%b fault=%b want 1/0", o_empty, o_fault);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) do_op(3'd4, W'(8'h20 + i));
    checks++;
    if (o_full !== 1'b1 || o_depth !== 3'd4 || o_fault !== 1'b0) begin
      errs++; $display("FAIL ovf_full: full=%b depth=%0d fault=%b want 1/4/0", o_full, o_depth, o_fault);
    end
    do_op(3'd4, 8'h24);
    checks++;
    if (o_fault !== 1'b1 || o_fault_code !== 2'd1 || o_data !== 8'h23 || o_depth !== 3'd4) begin
      errs++; $display("FAIL ovf_fault: fault=%b code=%0d pc=%h depth=%0d want 1/1/23/4", o_fault, o_fault_code, o_data, o_depth);
    end
    do_op(3'd1, 8'h00);
    checks++;
    if (o_data !== 8'h23 || o_fault_code !== 2'd1) begin
      errs++; $display("FAIL ovf_sticky: pc=%h code=%0d want 23/1", o_data, o_fault_code);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(3'd5, 8'h00);
    checks++;
    if (o_fault !== 1'b1 || o_fault_code !== 2'd2 || o_data !== 8'h00) begin
      errs++; $display("FAIL unf: fault=%b code=%0d pc=%h want 1/2/00", o_fault, o_fault_code, o_data);
    end
    // Asynchronous reset mid-sequence, checked before any clock edge.
    @(negedge mclk);
    mrst_n = 0;
    #1;
    checks++;
    if (o_data !== 8'h00 || o_depth !== 3'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
        o_fault !== 1'b0 || o_fault_code !== 2'd0) begin
      errs++;
      $display("FAIL async_reset: data=%h depth=%0d empty=%b full=%b fault=%b code=%0d want 00/0/1/0/0/0",
               o_data, o_depth, o_empty, o_full, o_fault, o_fault_code);
    end
    mdl_reset();
    @(negedge mclk);
    mrst_n = 1;
  endtask

  task automatic test_jrel();
    do_reset();
    do_op(3'd2, 8'h05);
    do_op(3'd3, 8'hFD);
    checks++;
`ifdef PSEQ_RELATIVE_EN
    if (o_data !== 8'h02 || o_fault !== 1'b0) begin
      errs++; $display("FAIL jrel: pc=%h fault=%b want 02/0", o_data, o_fault);
    end
`else
    if (o_data !== 8'h05 || o_fault_code !== 2'd3) begin
      errs++; $display("FAIL jrel_illegal: pc=%h code=%0d want 05/3", o_data, o_fault_code);
    end
`endif
    do_reset();
    do_op(3'd6 + 3'(($urandom_range(0, 1))), 8'h00);
    checks++;
    if (o_fault_code !== 2'd3 || o_data !== 8'h00) begin
      errs++; $display("FAIL illegal_op: code=%0d pc=%h want 3/00", o_fault_code, o_data);
    end
  endtask

  task automatic test_enable_halt();
    do_reset();
    do_op(3'd2, 8'h30);
    for (int i = 0; i < 5; i++) do_op(3'd1, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) do_op(3'd1, 8'h00, 1, 1);
    checks++;
    if (o_data !== 8'h30) begin errs++; $display("FAIL hold: pc=%h want 30", o_data); end
    for (int i = 1; i <= 3; i++) begin
      do_op(3'd1, 8'h00);
      checks++;
      if (o_data !== W'(8'h30 + i)) begin
        errs++; $display("FAIL reenable_%0d: pc=%h want %h", i, o_data, W'(8'h30 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    int         r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_flt && $urandom_range(0, 2) == 0) do_reset();
      r = $urandom_range(0, 99);
      if      (r < 25) op = 3'd1;
      else if (r < 40) op = 3'd2;
      else if (r < 65) op = 3'd4;
      else if (r < 88) op = 3'd5;
      else if (r < 94) op = 3'd0;
      else if (r < 97) op = 3'd3;
      else             op = 3'(6 + $urandom_range(0, 1));
      do_op(op, W'($urandom()), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
      checks++;
      if (o_data !== m_pc || o_depth !== 3'(m_stk.size()) || o_fault !== m_flt ||
          o_fault_code !== m_code || o_full !== (m_stk.size() == D) || o_empty !== (m_stk.size() == 0)) begin
        errs++;
        $display("FAIL rand_%0d op=%0d: pc=%h depth=%0d fault=%b code=%0d full=%b empty=%b want %h/%0d/%b/%0d/%b/%b",
                 n, op, o_data, o_depth, o_fault, o_fault_code, o_full, o_empty,
                 m_pc, m_stk.size(), m_flt, m_code, m_stk.size() == D, m_stk.size() == 0);
      end
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_inc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_jrel();
    test_enable_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
